// File: rtl/router_sync_if.sv
// Signal bundle between the router FSM/FIFOs and the router_sync glue block.
// The master side drives the FSM requests and FIFO status; the slave is router_sync.
interface router_sync_if;
   logic       detect_add;
   logic [1:0] data_in;
   logic       write_enb_reg;
   logic       read_enb_0, read_enb_1, read_enb_2;
   logic       empty_0, empty_1, empty_2;
   logic       full_0, full_1, full_2;
   logic [2:0] write_enb;
   logic       fifo_full;
   logic       vld_out_0, vld_out_1, vld_out_2;
   logic       soft_reset_0, soft_reset_1, soft_reset_2;

   modport master (
      output detect_add, data_in, write_enb_reg,
      output read_enb_0, read_enb_1, read_enb_2,
      output empty_0, empty_1, empty_2,
      output full_0, full_1, full_2,
      input  write_enb, fifo_full,
      input  vld_out_0, vld_out_1, vld_out_2,
      input  soft_reset_0, soft_reset_1, soft_reset_2
   );

   modport slave (
      input  detect_add, data_in, write_enb_reg,
      input  read_enb_0, read_enb_1, read_enb_2,
      input  empty_0, empty_1, empty_2,
      input  full_0, full_1, full_2,
      output write_enb, fifo_full,
      output vld_out_0, vld_out_1, vld_out_2,
      output soft_reset_0, soft_reset_1, soft_reset_2
   );
endinterface

// File: rtl/router_sync.sv
// 1x3 router glue: latches the header address, steers FIFO write enables, muxes the
// addressed full flag, and soft-resets any port whose data sits unread for TIMEOUT cycles.
module router_sync #(
   parameter int unsigned TIMEOUT = 30,
   parameter int unsigned CNT_W   = 5
) (
   input logic          clock,
   input logic          resetn,
   router_sync_if.slave bus
);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

   logic [1:0]       int_addr;
   logic [2:0]       empty, full, rd, vld, hold, soft_reset;
   logic [CNT_W-1:0] cnt [3];

   assign empty = {bus.empty_2, bus.empty_1, bus.empty_0};
   assign full  = {bus.full_2, bus.full_1, bus.full_0};
   assign rd    = {bus.read_enb_2, bus.read_enb_1, bus.read_enb_0};
   assign vld   = ~empty;
   assign hold  = vld & ~rd;

   assign bus.vld_out_0    = vld[0];
   assign bus.vld_out_1    = vld[1];
   assign bus.vld_out_2    = vld[2];
   assign bus.soft_reset_0 = soft_reset[0];
   assign bus.soft_reset_1 = soft_reset[1];
   assign bus.soft_reset_2 = soft_reset[2];

   always_ff @(posedge clock) begin
      if (!resetn) begin
         int_addr   <= 2'b11;
         soft_reset <= '0;
         for (int unsigned i = 0; i < 3; i++) cnt[i] <= '0;
      end else begin
         if (bus.detect_add) int_addr <= bus.data_in;
         // Counter wraps to zero on the pulse so a still-stuck port rearms.
         for (int unsigned i = 0; i < 3; i++) begin
            if (!hold[i]) begin
               cnt[i]        <= '0;
               soft_reset[i] <= 1'b0;
            end else if (cnt[i] == LAST) begin
               cnt[i]        <= '0;
               soft_reset[i] <= 1'b1;
            end else begin
               cnt[i]        <= cnt[i] + 1'b1;
               soft_reset[i] <= 1'b0;
            end
         end
      end
   end

   always_comb begin
      bus.write_enb = '0;
      bus.fifo_full = 1'b0;
      case (int_addr)
         2'b00: begin
            bus.write_enb = {2'b00, bus.write_enb_reg};
            bus.fifo_full = full[0];
         end
         2'b01: begin
            bus.write_enb = {1'b0, bus.write_enb_reg, 1'b0};
            bus.fifo_full = full[1];
         end
         2'b10: begin
            bus.write_enb = {bus.write_enb_reg, 2'b00};
            bus.fifo_full = full[2];
         end
         default: begin
            bus.write_enb = '0;
            bus.fifo_full = 1'b0;
         end
      endcase
   end
endmodule
